motion_sequencer: RTL and testbench
===================================

Name: motion_sequencer

Overview:
- Sits between the command backend and motor_driver; owns the five one-hot movement lines (fwd/bwd/left/right/stop) that feed motor_driver.
- Latches backend commands and inserts a stop dead-time on every forward/backward reversal to protect the H-bridges.
- Runs an autonomous escape manoeuvre when both line detectors fire while driving forward: back up, then turn right, then resume.
- Single-detector line steering stays in motor_driver.

Parameters:
- CNT_W, 20, width of the shared phase counter.
- DEAD_CYC, 5000, cycles of forced stop on a FWD<->BWD reversal; must be >=1.
- BACK_CYC, 50000, cycles of backward motion in the escape manoeuvre; must be >=1.
- TURN_CYC, 30000, cycles of right turn in the escape manoeuvre; must be >=1.
- WD_CYC, 100000, command watchdog timeout in cycles; used only with the macro.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  one-cycle strobe; cmd is sampled when high.
- cmd  in  3  command code: 0 STOP, 1 FWD, 2 BWD, 3 LEFT, 4 RIGHT; codes 5-7 are treated as STOP.
- ld_left  in  1  left line detector.
- ld_right  in  1  right line detector.
- fwd_out, bwd_out, left_out, right_out, stop_out  out  1 each  to motor_driver; registered, exactly one high at all times.
- state  out  3  FSM state: IDLE=0, RUN=1, DEAD=2, ESC_BACK=3, ESC_TURN=4.
- escape_active  out  1  high in ESC_BACK and ESC_TURN.
- wd_trip  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Reset (async assert, sync release): state=IDLE, active_cmd=STOP, counter=0, stop_out=1, all other outputs 0.
- active_cmd register: loaded from cmd on every cmd_valid, in every state.
- Output decode: registered from next-state and target; outputs change 1 cycle after the causing input edge.
  - IDLE and DEAD drive stop.
  - RUN drives active_cmd.
  - ESC_BACK drives bwd; ESC_TURN drives right.
- IDLE:
  - cmd_valid with a non-STOP code -> RUN, driving that command next cycle.
  - A STOP code keeps IDLE.
- RUN:
  - new command opposite in polarity to the one being driven (FWD->BWD or BWD->FWD) -> DEAD with target=RUN, counter=0.
  - STOP -> IDLE.
  - any other change applies directly, 1-cycle latency.
- RUN escape trigger: driving FWD and ld_left&&ld_right sampled high -> DEAD with target=ESC_BACK.
  - A simultaneous cmd_valid STOP wins -> IDLE.
  - A simultaneous cmd_valid with another code is latched; the escape still triggers.
- DEAD:
  - counter increments each cycle; at counter==DEAD_CYC-1 -> target, counter cleared.
  - cmd_valid during DEAD: STOP aborts to IDLE; other codes update active_cmd.
  - If target=RUN, the latest active_cmd is driven on exit; a latest cmd that is itself STOP exits to IDLE.
- ESC_BACK: BACK_CYC cycles, then ESC_TURN.
- ESC_TURN: TURN_CYC cycles, then resolve from active_cmd:
  - FWD -> RUN directly, no dead-time; turn to forward is not a reversal.
  - BWD -> DEAD with target=RUN.
  - STOP -> IDLE.
  - otherwise -> RUN.
- Escape abort: cmd_valid STOP in ESC_BACK or ESC_TURN -> IDLE next cycle. Other codes are latched only.
- Detector ignoring: ld inputs are ignored outside RUN. A re-trigger is possible on the first RUN cycle after an escape.
- Reset mid-operation: immediate return to reset values, no dead-time.

Optional Feature:
- Macro: MOTION_WATCHDOG_EN.
- Defined:
  - Counter wd_cnt is cleared on cmd_valid and reset; it increments otherwise, saturating.
  - When wd_cnt reaches WD_CYC-1 while state!=IDLE: active_cmd=STOP, state=IDLE next cycle, wd_trip high for exactly one cycle.
  - In IDLE the counter runs but causes no trip.
- Undefined: no watchdog logic; wd_trip is tied to 0.

Test Plan:
All scenarios use DEAD_CYC=2, BACK_CYC=4, TURN_CYC=3, WD_CYC=10.
- Reset: release rst_n, no stimulus -> stop_out=1, state=0, wd_trip=0. Assert rst_n low during RUN/FWD -> stop_out=1, state=0 without waiting for a clock.
- Direct command: cmd_valid cmd=1 at cycle t -> fwd_out=1, state=1 from t+1. Then cmd=3 at t+5 -> left_out=1 at t+6, no stop cycle.
- Reversal: in RUN/FWD, cmd=2 at t -> stop_out=1, state=2 at t+1..t+2; bwd_out=1, state=1 at t+3.
- Escape: in RUN/FWD, ld_left=ld_right=1 for one cycle at t -> expected output sequence:
  - stop at t+1..t+2;
  - bwd at t+3..t+6 with escape_active=1;
  - right at t+7..t+9;
  - fwd at t+10 with escape_active=0.
- Abort: cmd=0 during the second ESC_BACK cycle -> stop_out=1, state=0 on the next cycle, escape_active=0.
- Watchdog (macro on): cmd=1, then no cmd_valid -> wd_trip=1 for one cycle, after which stop_out=1 and state=0. With the macro off the same stimulus keeps fwd_out=1 indefinitely.

Source files
------------

// File: rtl/motion_sequencer_if.sv
// Command/detector inputs and movement/status outputs between the backend,
// motion_sequencer and motor_driver.
interface motion_sequencer_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       ld_left;
    logic       ld_right;
    logic       fwd_out;
    logic       bwd_out;
    logic       left_out;
    logic       right_out;
    logic       stop_out;
    logic [2:0] state;
    logic       escape_active;
    logic       wd_trip;

    modport master (
        output cmd_valid, cmd, ld_left, ld_right,
        input  fwd_out, bwd_out, left_out, right_out, stop_out,
        input  state, escape_active, wd_trip
    );

    modport slave (
        input  cmd_valid, cmd, ld_left, ld_right,
        output fwd_out, bwd_out, left_out, right_out, stop_out,
        output state, escape_active, wd_trip
    );
endinterface

// File: rtl/motion_sequencer.sv
// Movement sequencer: latches commands, inserts stop dead-time on reversals and runs the
// double-line escape manoeuvre. Optional command watchdog under MOTION_WATCHDOG_EN.
module motion_sequencer #(
    parameter int CNT_W    = 20,
    parameter int DEAD_CYC = 5000,
    parameter int BACK_CYC = 50000,
    parameter int TURN_CYC = 30000,
    parameter int WD_CYC   = 100000
) (
    input logic              clk,
    input logic              rst_n,
    motion_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        DEAD     = 3'd2,
        ESC_BACK = 3'd3,
        ESC_TURN = 3'd4
    } state_t;

    localparam logic [2:0] C_STOP  = 3'd0;
    localparam logic [2:0] C_FWD   = 3'd1;
    localparam logic [2:0] C_BWD   = 3'd2;
    localparam logic [2:0] C_LEFT  = 3'd3;
    localparam logic [2:0] C_RIGHT = 3'd4;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

    if (DEAD_CYC < 1 || BACK_CYC < 1 || TURN_CYC < 1 || WD_CYC < 1) begin : g_bad_cfg
        $error("motion_sequencer: all cycle counts must be >= 1");
    end

    // Movement lines packed as {stop, right, left, bwd, fwd}.
    function automatic logic [4:0] decode(input state_t s, input logic [2:0] c);
        logic [4:0] m;
        m = 5'b10000;
        case (s)
            RUN: begin
                case (c)
                    C_FWD:   m = 5'b00001;
                    C_BWD:   m = 5'b00010;
                    C_LEFT:  m = 5'b00100;
                    C_RIGHT: m = 5'b01000;
                    default: m = 5'b10000;
                endcase
            end
            ESC_BACK: m = 5'b00010;
            ESC_TURN: m = 5'b01000;
            default:  m = 5'b10000;
        endcase
        return m;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       active_cmd_q, active_cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_esc_q, tgt_esc_d;
    logic [4:0]       mv_q, mv_d;
    logic [2:0]       next_cmd;
    logic             stop_req;
    logic             reversal;
    logic             wd_fire;

    assign next_cmd = bus.cmd_valid ? ((bus.cmd > C_RIGHT) ? C_STOP : bus.cmd) : active_cmd_q;
    assign stop_req = bus.cmd_valid && (next_cmd == C_STOP);
    assign reversal = ((active_cmd_q == C_FWD) && (next_cmd == C_BWD)) ||
                      ((active_cmd_q == C_BWD) && (next_cmd == C_FWD));

`ifdef MOTION_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_CYC - 1);
    logic [CNT_W-1:0] wd_cnt_q;
    logic             wd_trip_q;

    // Saturates at the trip value so an expired count stays visible until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_trip_q <= wd_fire;
            if (bus.cmd_valid)
                wd_cnt_q <= '0;
            else if (wd_cnt_q != WD_LAST)
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end

    assign wd_fire     = (wd_cnt_q == WD_LAST) && !bus.cmd_valid && (state_q != IDLE);
    assign bus.wd_trip = wd_trip_q;
`else
    assign wd_fire     = 1'b0;
    assign bus.wd_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_cmd_q <= C_STOP;
            cnt_q        <= '0;
            tgt_esc_q    <= 1'b0;
            mv_q         <= 5'b10000;
        end else begin
            state_q      <= state_d;
            active_cmd_q <= active_cmd_d;
            cnt_q        <= cnt_d;
            tgt_esc_q    <= tgt_esc_d;
            mv_q         <= mv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        active_cmd_d = next_cmd;
        cnt_d        = '0;
        tgt_esc_d    = tgt_esc_q;
        case (state_q)
            IDLE: if (bus.cmd_valid && !stop_req) state_d = RUN;
            RUN: begin
                // STOP beats the escape trigger; the escape beats a plain reversal.
                if (stop_req) begin
                    state_d = IDLE;
                end else if ((active_cmd_q == C_FWD) && bus.ld_left && bus.ld_right) begin
                    state_d   = DEAD;
                    tgt_esc_d = 1'b1;
                end else if (reversal) begin
                    state_d   = DEAD;
                    tgt_esc_d = 1'b0;
                end
            end
            DEAD: begin
                if (stop_req)               state_d = IDLE;
                else if (cnt_q == DEAD_LAST) begin
                    if (tgt_esc_q)               state_d = ESC_BACK;
                    else if (next_cmd == C_STOP) state_d = IDLE;
                    else                         state_d = RUN;
                end else                    cnt_d = cnt_q + CNT_W'(1);
            end
            ESC_BACK: begin
                if (stop_req)                state_d = IDLE;
                else if (cnt_q == BACK_LAST) state_d = ESC_TURN;
                else                         cnt_d = cnt_q + CNT_W'(1);
            end
            ESC_TURN: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else if (cnt_q == TURN_LAST) begin
                    // Turning into forward is not a reversal; only backward needs dead-time.
                    case (next_cmd)
                        C_BWD: begin
                            state_d   = DEAD;
                            tgt_esc_d = 1'b0;
                        end
                        C_STOP:  state_d = IDLE;
                        default: state_d = RUN;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (wd_fire) begin
            state_d      = IDLE;
            active_cmd_d = C_STOP;
            cnt_d        = '0;
        end
    end

    always_comb begin
        mv_d = decode(state_d, active_cmd_d);
    end

    assign bus.fwd_out       = mv_q[0];
    assign bus.bwd_out       = mv_q[1];
    assign bus.left_out      = mv_q[2];
    assign bus.right_out     = mv_q[3];
    assign bus.stop_out      = mv_q[4];
    assign bus.state         = state_q;
    assign bus.escape_active = (state_q == ESC_BACK) || (state_q == ESC_TURN);
endmodule

// File: tb/tb_motion_sequencer.sv
// Scoreboard bench for motion_sequencer with DEAD_CYC=2, BACK_CYC=4, TURN_CYC=3, WD_CYC=10.
module tb_motion_sequencer;
    localparam logic [4:0] MF = 5'b00001;
    localparam logic [4:0] MB = 5'b00010;
    localparam logic [4:0] ML = 5'b00100;
    localparam logic [4:0] MR = 5'b01000;
    localparam logic [4:0] MS = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] mv;
        logic [2:0] st;
        logic       esc;
        logic       wd;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    motion_sequencer_if bus();

    motion_sequencer #(
        .CNT_W(20), .DEAD_CYC(2), .BACK_CYC(4), .TURN_CYC(3), .WD_CYC(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    function automatic logic [4:0] act_mv();
        return {bus.stop_out, bus.right_out, bus.left_out, bus.bwd_out, bus.fwd_out};
    endfunction

    // Monitor: pops every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || act_mv() !== e.mv || bus.state !== e.st ||
                bus.escape_active !== e.esc || bus.wd_trip !== e.wd) begin
                errors++;
                $display("FAIL %s cyc=%0d: got mv=%b st=%0d esc=%b wd=%b, want mv=%b st=%0d esc=%b wd=%b (due %0d)",
                         e.nm, cyc, act_mv(), bus.state, bus.escape_active, bus.wd_trip,
                         e.mv, e.st, e.esc, e.wd, e.cyc);
            end
        end
    end

    task automatic step(input logic v, input logic [2:0] c, input logic l, input logic r,
                        input logic [4:0] mv, input logic [2:0] st, input logic esc,
                        input logic wd, input string nm);
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = v;
        bus.cmd       = c;
        bus.ld_left   = l;
        bus.ld_right  = r;
        e.cyc = cyc + 1;
        e.mv  = mv;
        e.st  = st;
        e.esc = esc;
        e.wd  = wd;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic hold(input logic [4:0] mv, input logic [2:0] st, input logic esc, input string nm);
        step(1'b0, 3'd0, 1'b0, 1'b0, mv, st, esc, 1'b0, nm);
    endtask

    task automatic cmdv(input logic [2:0] c, input logic [4:0] mv, input logic [2:0] st,
                        input logic esc, input string nm);
        step(1'b1, c, 1'b0, 1'b0, mv, st, esc, 1'b0, nm);
    endtask

    task automatic chk_now(input string nm, input logic [4:0] mv, input logic [2:0] st);
        checks++;
        if (act_mv() !== mv || bus.state !== st || bus.escape_active !== 1'b0 || bus.wd_trip !== 1'b0) begin
            errors++;
            $display("FAIL %s: got mv=%b st=%0d esc=%b wd=%b, want mv=%b st=%0d esc=0 wd=0",
                     nm, act_mv(), bus.state, bus.escape_active, bus.wd_trip, mv, st);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'd0;
        bus.ld_left   = 1'b0;
        bus.ld_right  = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_now("rst_hold", MS, 3'd0);
        @(negedge clk) rst_n = 1'b1;

        hold(MS, 0, 0, "rst_idle");
        hold(MS, 0, 0, "rst_idle");

        cmdv(3'd1, MF, 1, 0, "cmd_fwd");
        repeat (4) hold(MF, 1, 0, "hold_fwd");
        cmdv(3'd3, ML, 1, 0, "cmd_left");
        cmdv(3'd1, MF, 1, 0, "left_to_fwd");

        cmdv(3'd2, MS, 2, 0, "rev_dead1");
        hold(MS, 2, 0, "rev_dead2");
        hold(MB, 1, 0, "rev_bwd");
        hold(MB, 1, 0, "rev_bwd_hold");
        cmdv(3'd1, MS, 2, 0, "rev2_dead1");
        hold(MS, 2, 0, "rev2_dead2");
        hold(MF, 1, 0, "rev2_fwd");

        step(1'b0, 3'd0, 1'b1, 1'b1, MS, 2, 0, 0, "esc_dead1");
        step(1'b0, 3'd0, 1'b1, 1'b1, MS, 2, 0, 0, "esc_dead2_ld_ignored");
        repeat (3) hold(MB, 3, 1, "esc_back");
        cmdv(3'd1, MB, 3, 1, "esc_back_latch");
        repeat (3) hold(MR, 4, 1, "esc_turn");
        hold(MF, 1, 0, "esc_resume");

        step(1'b1, 3'd0, 1'b1, 1'b1, MS, 0, 0, 0, "esc_stop_wins");

        cmdv(3'd1, MF, 1, 0, "abort_fwd");
        step(1'b0, 3'd0, 1'b1, 1'b1, MS, 2, 0, 0, "abort_dead1");
        hold(MS, 2, 0, "abort_dead2");
        hold(MB, 3, 1, "abort_back1");
        hold(MB, 3, 1, "abort_back2");
        cmdv(3'd0, MS, 0, 0, "abort_stop");
        hold(MS, 0, 0, "abort_idle");

        cmdv(3'd1, MF, 1, 0, "esc2_fwd");
        step(1'b0, 3'd0, 1'b1, 1'b1, MS, 2, 0, 0, "esc2_dead1");
        hold(MS, 2, 0, "esc2_dead2");
        hold(MB, 3, 1, "esc2_back");
        cmdv(3'd2, MB, 3, 1, "esc2_latch_bwd");
        repeat (2) hold(MB, 3, 1, "esc2_back");
        repeat (3) hold(MR, 4, 1, "esc2_turn");
        hold(MS, 2, 0, "turn_to_dead1");
        hold(MS, 2, 0, "turn_to_dead2");
        hold(MB, 1, 0, "dead_to_bwd");
        cmdv(3'd6, MS, 0, 0, "code6_stop");

        cmdv(3'd1, MF, 1, 0, "dab_fwd");
        cmdv(3'd2, MS, 2, 0, "dab_rev");
        cmdv(3'd0, MS, 0, 0, "dead_abort_stop");
        hold(MS, 0, 0, "dab_idle");

        cmdv(3'd1, MF, 1, 0, "dlt_fwd");
        cmdv(3'd2, MS, 2, 0, "dlt_rev");
        cmdv(3'd3, MS, 2, 0, "dead_latch_left");
        hold(ML, 1, 0, "dead_exit_left");

`ifdef MOTION_WATCHDOG_EN
        cmdv(3'd1, MF, 1, 0, "wd_fwd");
        repeat (9) hold(MF, 1, 0, "wd_hold");
        step(1'b0, 3'd0, 1'b0, 1'b0, MS, 0, 0, 1, "wd_trip");
        hold(MS, 0, 0, "wd_idle");
        hold(MS, 0, 0, "wd_idle");
`else
        cmdv(3'd1, MF, 1, 0, "nowd_fwd");
        repeat (15) hold(MF, 1, 0, "nowd_hold");
`endif

        cmdv(3'd1, MF, 1, 0, "pre_rst_fwd");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_now("async_rst", MS, 3'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
